// File: rtl/location_scanner.sv
// location_scanner: multi-cycle snake hit detector, scans LANES body slots per clock.
// Answers head/body queries or head-vs-body self-collision and reports the lowest matching slot.
module location_scanner #(
    parameter int MAX_LENGTH = 50,
    parameter int COORD_W    = 8,
    parameter int LEN_W      = 7,
    parameter int LANES      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          mode_i,
    input  logic [COORD_W-1:0]            coordinate_i,
    input  logic [MAX_LENGTH*COORD_W-1:0] body_i,
    input  logic [LEN_W-1:0]              curr_length_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          snake_head_o,
    output logic                          snake_body_o,
    output logic [LEN_W-1:0]              hit_index_o
);
    localparam int IW = MAX_LENGTH > 1 ? $clog2(MAX_LENGTH) : 1;
    localparam logic [LEN_W:0]   LN   = (LEN_W+1)'(LANES);
    localparam logic [LEN_W:0]   ML   = (LEN_W+1)'(MAX_LENGTH);
    localparam logic [LEN_W-1:0] LAST = LEN_W'(MAX_LENGTH-1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q;
    logic [COORD_W-1:0] key_q;
    logic               mode_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W:0]     base_q;
    logic               busy_q, done_q, head_q, body_q;
    logic [LEN_W-1:0]   idx_q;
    logic               acc_head_q, acc_body_q, acc_head_d, acc_body_d;
    logic [LEN_W-1:0]   acc_idx_q, acc_idx_d;
    logic               first_b, last;
    logic [LEN_W-1:0]   first_i;
    logic [COORD_W-1:0] seg [MAX_LENGTH];
    logic [LANES-1:0]   lane_m;
    logic [LEN_W:0]     lane_s [LANES];

    for (genvar s = 0; s < MAX_LENGTH; s++) begin : g_seg
        assign seg[s] = body_i[s*COORD_W +: COORD_W];
    end

    // Slot 0 in self-collision mode is the key itself, so it never counts as a match.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic          valid;
        logic [IW-1:0] idx;
        assign lane_s[l] = base_q + (LEN_W+1)'(l);
        assign valid     = lane_s[l] <= {1'b0, len_q} && lane_s[l] < ML;
        assign idx       = valid ? lane_s[l][IW-1:0] : '0;
        assign lane_m[l] = valid && seg[idx] == key_q && !(mode_q && lane_s[l] == '0);
    end

    always_comb begin
        first_b = 1'b0;
        first_i = '0;
        for (int k = LANES-1; k >= 0; k--) begin
            if (lane_m[k] && lane_s[k] != '0) begin
                first_b = 1'b1;
                first_i = lane_s[k][LEN_W-1:0];
            end
        end
        acc_head_d = acc_head_q | (lane_m[0] && base_q == '0);
        acc_body_d = acc_body_q | first_b;
        acc_idx_d  = acc_body_q ? acc_idx_q : first_i;
        last       = base_q + LN > {1'b0, len_q};
    end

    // Results accumulate privately and are published only with done, so outputs read 0 mid-scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            mode_q     <= 1'b0;
            len_q      <= '0;
            base_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            head_q     <= 1'b0;
            body_q     <= 1'b0;
            idx_q      <= '0;
            acc_head_q <= 1'b0;
            acc_body_q <= 1'b0;
            acc_idx_q  <= '0;
        end else if (state_q == IDLE) begin
            done_q <= 1'b0;
            if (start_i) begin
                state_q    <= SCAN;
                busy_q     <= 1'b1;
                key_q      <= mode_i ? seg[0] : coordinate_i;
                mode_q     <= mode_i;
                len_q      <= curr_length_i > LAST ? LAST : curr_length_i;
                base_q     <= '0;
                head_q     <= 1'b0;
                body_q     <= 1'b0;
                idx_q      <= '0;
                acc_head_q <= 1'b0;
                acc_body_q <= 1'b0;
                acc_idx_q  <= '0;
            end
        end else begin
            acc_head_q <= acc_head_d;
            acc_body_q <= acc_body_d;
            acc_idx_q  <= acc_idx_d;
            if (last) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                head_q  <= acc_head_d;
                body_q  <= acc_body_d;
                idx_q   <= acc_idx_d;
            end else begin
                base_q <= base_q + LN;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign snake_head_o = head_q;
    assign snake_body_o = body_q;
    assign hit_index_o  = idx_q;
endmodule

// File: tb/tb_location_scanner.sv
// tb_location_scanner: directed and randomized requests checked against a loop-based reference model.
module tb_location_scanner;
    localparam int ML = 50;
    localparam int CW = 8;
    localparam int LW = 7;
    localparam int LN = 4;

    logic            clk = 1'b0;
    logic            rst, start, mode;
    logic [CW-1:0]   coordinate;
    logic [ML*CW-1:0] body;
    logic [LW-1:0]   curr_length;
    logic            busy, done, snake_head, snake_body;
    logic [LW-1:0]   hit_index;
    logic [CW-1:0]   bd [ML];
    logic [8:0]      last_res;
    int              n_chk = 0;
    int              n_pass = 0;

    for (genvar g = 0; g < ML; g++) begin : g_body
        assign body[g*CW +: CW] = bd[g];
    end

    location_scanner #(.MAX_LENGTH(ML), .COORD_W(CW), .LEN_W(LW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .coordinate_i(coordinate),
        .body_i(body), .curr_length_i(curr_length), .busy_o(busy), .done_o(done),
        .snake_head_o(snake_head), .snake_body_o(snake_body), .hit_index_o(hit_index)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] obs();
        return {busy, done, snake_head, snake_body, hit_index};
    endfunction

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got {busy,done,head,body,idx}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
                     tag, got[10], got[9], got[8], got[7], got[6:0], exp[10], exp[9], exp[8], exp[7], exp[6:0]);
        else
            n_pass++;
    endtask

    task automatic fill_distinct();
        for (int i = 0; i < ML; i++) bd[i] = 8'(8'h80 + i);
    endtask

    // Drive one request at the current negedge and follow it through to done.
    task automatic run_req(input string tag, input bit m, input logic [CW-1:0] coord,
                           input logic [LW-1:0] cl, input int poke, input int abort);
        int            len, c;
        bit            eh, eb;
        logic [LW-1:0] ei;
        logic [CW-1:0] key;
        len = int'(cl) > ML-1 ? ML-1 : int'(cl);
        key = m ? bd[0] : coord;
        eh  = !m && bd[0] == key;
        eb  = 1'b0;
        ei  = '0;
        for (int i = 1; i <= len; i++)
            if (!eb && bd[i] == key) begin
                eb = 1'b1;
                ei = LW'(i);
            end
        c = len / LN + 1;
        start = 1'b1; mode = m; coordinate = coord; curr_length = cl;
        @(negedge clk);
        start = 1'b0; coordinate = ~coord; curr_length = 7'($urandom_range(0, 127));
        for (int k = 1; k <= c; k++) begin
            check({tag, ":scan"}, obs(), 11'h400);
            if (k == abort) begin
                rst = 1'b1;
                @(negedge clk);
                check({tag, ":abort_rst"}, obs(), 11'h000);
                rst = 1'b0;
                @(negedge clk);
                check({tag, ":abort_nodone"}, obs(), 11'h000);
                last_res = '0;
                return;
            end
            if (k == poke) begin
                start = 1'b1;
                coordinate = coord ^ 8'h5a;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, ":done"}, obs(), {2'b01, eh, eb, ei});
        last_res = {eh, eb, ei};
    endtask

    task automatic hold_check(input string tag);
        @(negedge clk);
        check({tag, ":hold"}, obs(), {2'b00, last_res});
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; mode = 1'b0; coordinate = 8'h23; curr_length = 7'd3;
        last_res = '0;
        fill_distinct();
        @(negedge clk);
        check("reset_c1", obs(), 11'h000);
        @(negedge clk);
        check("reset_c2", obs(), 11'h000);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_idle", obs(), 11'h000);

        bd[0] = 8'h23; bd[1] = 8'h10; bd[2] = 8'h10; bd[3] = 8'h10;
        run_req("head", 1'b0, 8'h23, 7'd3, 0, 0);
        hold_check("head");

        fill_distinct(); bd[5] = 8'h11; bd[7] = 8'h11;
        run_req("multi_poke", 1'b0, 8'h11, 7'd9, 2, 0);
        hold_check("multi_poke");

        fill_distinct(); bd[10] = 8'h55;
        run_req("len9", 1'b0, 8'h55, 7'd9, 0, 0);
        run_req("len10", 1'b0, 8'h55, 7'd10, 0, 0);

        fill_distinct(); bd[0] = 8'h42; bd[4] = 8'h42;
        run_req("self", 1'b1, 8'h00, 7'd6, 0, 0);

        fill_distinct();
        run_req("clamp", 1'b1, 8'h00, 7'd100, 0, 0);
        bd[49] = 8'h77;
        run_req("clamp_last", 1'b0, 8'h77, 7'd127, 0, 0);
        hold_check("clamp_last");

        fill_distinct(); bd[5] = 8'h33;
        run_req("abort", 1'b0, 8'h33, 7'd9, 0, 2);
        run_req("fresh", 1'b0, 8'h33, 7'd9, 0, 0);
        hold_check("fresh");

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < ML; i++) bd[i] = 8'($urandom_range(0, 15));
            run_req("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                    7'($urandom_range(0, 127)), 0, 0);
            if ($urandom_range(0, 1) == 1) hold_check("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/location_scanner.md
# location_scanner

Multi-cycle, parametrised snake-segment hit detector that replaces the single-cycle, MAX_LENGTH-wide comparator array with a scan of LANES comparators per clock. It sits between the game-state logic (snake body array, current length) and the pixel/collision logic. It answers one of two questions per request: does a query coordinate land on the head or on the body, or (self-collision mode) does the head overlap any body segment. Every result carries the lowest matching body index.

## Interface
- MAX_LENGTH, 50, number of segment slots in `body`; slot 0 is the head.
- COORD_W, 8, width of one packed coordinate.
- LEN_W, 7, width of `curr_length` and `hit_index`; must satisfy 2^LEN_W > MAX_LENGTH-1.
- LANES, 4, segments compared per scan cycle; 1 ≤ LANES ≤ MAX_LENGTH.

- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only while idle.
- mode  in  1  0 = query `coordinate`; 1 = self-collision (compare body[0] against body slots).
- coordinate  in  COORD_W  query coordinate; latched on accepted start.
- body  in  MAX_LENGTH×COORD_W  segment array; requester holds stable while `busy`.
- curr_length  in  LEN_W  index of last valid body slot; latched on accepted start.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; results valid.
- snake_head  out  1  query coordinate equals body[0] (mode 0 only).
- snake_body  out  1  a match on some slot i, 1 ≤ i ≤ effective length.
- hit_index  out  LEN_W  lowest matching body slot; 0 when `snake_body`=0.

## Operation
- Two states: IDLE and SCAN.
- In IDLE, when start=1:
  - latch the key: `coordinate` in mode 0, body[0] in mode 1.
  - latch mode.
  - latch len = min(curr_length, MAX_LENGTH-1).
  - set base=0, clear snake_head/snake_body/hit_index, enter SCAN.
- In SCAN, each cycle compares slots base … base+LANES-1 against the key.
- A slot i is valid when i ≤ len and i < MAX_LENGTH.
- Slot 0 match:
  - mode 0: sets snake_head.
  - mode 1: ignored, because the head always equals itself.
- Slot i ≥ 1 match sets snake_body.
- hit_index takes the lowest matching i. The first hit is kept; later, higher hits never overwrite it.
- If base+LANES > len, this is the last scan cycle: next state IDLE, done=1 in the following cycle. Otherwise base += LANES.
- start while busy is ignored; no queueing.
- Results hold their values from done until the next accepted start clears them.
- rst in any state: IDLE, base=0, all outputs 0. A scan in flight is abandoned with no done.
- base counter width is LEN_W+1, so base+LANES never wraps.

## Timing
- Scan cycles: C = floor(len/LANES) + 1.
- start high in cycle 0 (IDLE): busy=1 in cycles 1…C.
- In cycle C+1: done=1, busy=0, results valid. snake_head, snake_body and hit_index are registered and stable from this cycle on.
- Outputs read 0 during cycles 1…C.
- A new start may be asserted in cycle C+1, giving back-to-back requests with zero idle gap. Throughput is one request per C+1 cycles.
- Reset value of every output is 0: busy, done, snake_head, snake_body, hit_index.
- body changes during busy are a requester error; the result is undefined but the FSM still completes in C cycles.

## Test plan
- Reset: assert rst 2 cycles with start=1 → busy=done=snake_head=snake_body=0, hit_index=0; no scan begins.
- Head query: LANES=4, body[0]=0x23, body[1..3]=0x10, curr_length=3, mode=0, coordinate=0x23, start → C=1, done in cycle 2, snake_head=1, snake_body=0, hit_index=0.
- Multi-hit / first-hit: curr_length=9, body[5]=body[7]=0x11, others distinct, coordinate=0x11 → busy cycles 1–3, done in cycle 4, snake_body=1, hit_index=5, snake_head=0.
- Length boundary:
  - body[10]=coordinate, curr_length=9 → snake_body=0, hit_index=0.
  - Same with curr_length=10 → snake_body=1, hit_index=10, C=3.
- Self-collision and clamp:
  - mode=1, body[0]=body[4]=0x42, curr_length=6 → snake_head=0, snake_body=1, hit_index=4.
  - curr_length=100, all slots distinct → len clamped to 49, C=13, snake_body=0.
- Busy/reset interaction:
  - start pulsed in cycle 2 of a 3-cycle scan → ignored, single done.
  - rst in cycle 2 → busy=0, no done.
  - Next start → correct fresh result.
